// File: rtl/serial_parity_tx.sv
// serial_parity_tx: valid/ready word in, start + LSB-first data + parity + stop bit out on tx
module serial_parity_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_W + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [BW-1:0]     idx, idx_nx;
   logic [DATA_W-1:0] shift, shift_nx;
   logic              par, par_nx, tx_nx, done_nx, accept, last;
   assign ready  = state == IDLE && rst_n;
   assign busy   = state != IDLE;
   assign accept = valid && ready;
   assign last   = cnt == CW'(CLKS_PER_BIT - 1);
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      case (state)
         IDLE:    state_nx = accept ? START : IDLE;
         START:   state_nx = last ? DATA : START;
         DATA:    state_nx = last && idx == BW'(DATA_W - 1) ? PARITY : DATA;
         PARITY:  state_nx = last ? STOP : PARITY;
         STOP: begin
            state_nx = last ? IDLE : STOP;
            done_nx  = last;
         end
         default: state_nx = IDLE;
      endcase
      cnt_nx   = state_nx != state || state == IDLE || last ? '0 : cnt + CW'(1);
      idx_nx   = state_nx != state ? '0 : state == DATA && last ? idx + BW'(1) : idx;
      shift_nx = accept ? data_in : state == DATA && last ? shift >> 1 : shift;
      par_nx   = accept ? ^data_in ^ PARITY_ODD : par;
      // tx is registered, so it is computed from the state being entered
      tx_nx    = state_nx == START  ? 1'b0 :
                 state_nx == DATA   ? shift_nx[0] :
                 state_nx == PARITY ? par_nx : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         shift <= shift_nx;
         par   <= par_nx;
         tx    <= tx_nx;
         done  <= done_nx;
      end
   end
endmodule
